// File: rtl/alu_issue.sv
// alu_issue: registered RV32I issue stage feeding the ALU operand/opsel interface.
// Decodes a raw instruction into opsel/op1/op2/rd/wen/illegal. The decoded op is
// held in an output register backed by one skid entry, so o_ready comes straight
// from a flop.
// Optional build macro ALU_ISSUE_STATS_EN adds o_issue_cnt / o_illegal_cnt.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | output register invalid, skid empty
// ST_ONE   | output register valid, skid empty
// ST_FULL  | output register and skid both valid
module alu_issue #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [3:0]      o_opsel,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [RD_W-1:0] o_rd,
    output logic            o_wen,
    output logic            o_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]     o_issue_cnt,
    output logic [31:0]     o_illegal_cnt
`endif
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_SLL   = 4'h2;
    localparam logic [3:0] OP_SLT   = 4'h3;
    localparam logic [3:0] OP_SLTU  = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SRA   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_PASSB = 4'hA;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // ---------------- decode ----------------
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic            w_legal;
    logic [3:0]      w_dec_opsel;
    logic [XLEN-1:0] w_dec_op1;
    logic [XLEN-1:0] w_dec_op2;
    logic [RD_W-1:0] w_dec_rd;
    logic            w_dec_wen;
    logic            w_unused;

    assign w_opc    = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];
    assign w_imm_i  = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_u  = XLEN'({i_inst[31:12], 12'b0});
    assign w_shamt  = XLEN'(i_inst[24:20]);
    assign w_dec_rd = RD_W'(i_inst[11:7]);
    // Register indices are resolved upstream; only their data arrives here.
    assign w_unused = ^i_inst[19:15];

    // Combinational decode of the incoming instruction; illegal ops zero the operands.
    always_comb begin
        w_legal     = 1'b1;
        w_dec_opsel = OP_ADD;
        w_dec_op1   = '0;
        w_dec_op2   = '0;
        case (w_opc)
            OPC_OP: begin
                w_dec_op1 = i_rs1_data;
                w_dec_op2 = i_rs2_data;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        3'd0: w_dec_opsel = OP_ADD;
                        3'd1: w_dec_opsel = OP_SLL;
                        3'd2: w_dec_opsel = OP_SLT;
                        3'd3: w_dec_opsel = OP_SLTU;
                        3'd4: w_dec_opsel = OP_XOR;
                        3'd5: w_dec_opsel = OP_SRL;
                        3'd6: w_dec_opsel = OP_OR;
                        default: w_dec_opsel = OP_AND;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == 3'd0) begin
                    w_dec_opsel = OP_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == 3'd5) begin
                    w_dec_opsel = OP_SRA;
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_IMM: begin
                w_dec_op1 = i_rs1_data;
                w_dec_op2 = w_imm_i;
                case (w_f3)
                    3'd0: w_dec_opsel = OP_ADD;
                    3'd1: begin
                        w_dec_opsel = OP_SLL;
                        w_dec_op2   = w_shamt;
                        w_legal     = (w_f7 == F7_BASE);
                    end
                    3'd2: w_dec_opsel = OP_SLT;
                    3'd3: w_dec_opsel = OP_SLTU;
                    3'd4: w_dec_opsel = OP_XOR;
                    3'd5: begin
                        w_dec_op2 = w_shamt;
                        if (w_f7 == F7_BASE) begin
                            w_dec_opsel = OP_SRL;
                        end else if (w_f7 == F7_ALT) begin
                            w_dec_opsel = OP_SRA;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    3'd6: w_dec_opsel = OP_OR;
                    default: w_dec_opsel = OP_AND;
                endcase
            end
            OPC_LUI: begin
                w_dec_opsel = OP_PASSB;
                w_dec_op2   = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec_opsel = OP_ADD;
                w_dec_op1   = i_pc;
                w_dec_op2   = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_dec_opsel = OP_ADD;
            w_dec_op1   = '0;
            w_dec_op2   = '0;
        end
    end

    assign w_dec_wen = w_legal && (w_dec_rd != '0);

    // ---------------- buffer control ----------------
    state_t r_state;
    state_t w_state_nxt;
    logic   r_ready;
    logic   w_out_valid;
    logic   w_accept;
    logic   w_drain;
    logic   w_ld_out_in;
    logic   w_ld_out_skid;
    logic   w_ld_skid;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = i_valid && r_ready;
    assign w_drain     = w_out_valid && i_ready;

    // State register; ready is registered from the next state so it never sees inputs combinationally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Next-state and load-select logic for the output/skid pair.
    always_comb begin
        w_state_nxt   = r_state;
        w_ld_out_in   = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_ld_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_ld_out_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_state_nxt   = ST_ONE;
                    w_ld_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---------------- data registers ----------------
    logic [3:0]      r_out_opsel, r_skid_opsel;
    logic [XLEN-1:0] r_out_op1,   r_skid_op1;
    logic [XLEN-1:0] r_out_op2,   r_skid_op2;
    logic [RD_W-1:0] r_out_rd,    r_skid_rd;
    logic            r_out_wen,   r_skid_wen;
    logic            r_out_ill,   r_skid_ill;

    // Output register loads from decode or from the skid entry; otherwise it holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_opsel <= '0;
            r_out_op1   <= '0;
            r_out_op2   <= '0;
            r_out_rd    <= '0;
            r_out_wen   <= 1'b0;
            r_out_ill   <= 1'b0;
        end else if (w_ld_out_in) begin
            r_out_opsel <= w_dec_opsel;
            r_out_op1   <= w_dec_op1;
            r_out_op2   <= w_dec_op2;
            r_out_rd    <= w_dec_rd;
            r_out_wen   <= w_dec_wen;
            r_out_ill   <= !w_legal;
        end else if (w_ld_out_skid) begin
            r_out_opsel <= r_skid_opsel;
            r_out_op1   <= r_skid_op1;
            r_out_op2   <= r_skid_op2;
            r_out_rd    <= r_skid_rd;
            r_out_wen   <= r_skid_wen;
            r_out_ill   <= r_skid_ill;
        end
    end

    // Skid entry captures the op accepted while the output is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_opsel <= '0;
            r_skid_op1   <= '0;
            r_skid_op2   <= '0;
            r_skid_rd    <= '0;
            r_skid_wen   <= 1'b0;
            r_skid_ill   <= 1'b0;
        end else if (w_ld_skid) begin
            r_skid_opsel <= w_dec_opsel;
            r_skid_op1   <= w_dec_op1;
            r_skid_op2   <= w_dec_op2;
            r_skid_rd    <= w_dec_rd;
            r_skid_wen   <= w_dec_wen;
            r_skid_ill   <= !w_legal;
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = w_out_valid;
    assign o_opsel   = r_out_opsel;
    assign o_op1     = r_out_op1;
    assign o_op2     = r_out_op2;
    assign o_rd      = r_out_rd;
    assign o_wen     = r_out_wen;
    assign o_illegal = r_out_ill;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_illegal_cnt;

    // Issue/illegal counters advance on each downstream transfer and wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issue_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else if (w_drain) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
            if (r_out_ill) begin
                r_illegal_cnt <= r_illegal_cnt + 32'd1;
            end
        end
    end

    assign o_issue_cnt   = r_issue_cnt;
    assign o_illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed decode cases, stall/skid ordering, illegal
// handling, reset while full, and a randomized stream against a queue model.
module tb_alu_issue;

    typedef struct packed {
        logic        ill;
        logic        wen;
        logic [4:0]  rd;
        logic [3:0]  opsel;
        logic [31:0] op1;
        logic [31:0] op2;
    } op_t;

    // opsel of the base (funct7=0) op for each funct3; the alternate form is one higher.
    localparam int BASE_SEL [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_inst;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_pc;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_opsel;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic [4:0]  o_rd;
    logic        o_wen;
    logic        o_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] o_issue_cnt;
    logic [31:0] o_illegal_cnt;
`endif

    int passed = 0;
    int total  = 0;
    op_t q[$];

    alu_issue #(.XLEN(32), .RD_W(5)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_inst(i_inst),
        .i_rs1_data(i_rs1_data),
        .i_rs2_data(i_rs2_data),
        .i_pc(i_pc),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_opsel(o_opsel),
        .o_op1(o_op1),
        .o_op2(o_op2),
        .o_rd(o_rd),
        .o_wen(o_wen),
        .o_illegal(o_illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .o_issue_cnt(o_issue_cnt),
        .o_illegal_cnt(o_illegal_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    // Reference: what the issued op should be, from the instruction-set rules.
    function automatic op_t model(input logic [31:0] inst, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] pc);
        op_t r;
        logic ok;
        int sel;
        logic [31:0] a, b, imm_i, imm_u;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        imm_i = 32'($signed(inst[31:20]));
        imm_u = {inst[31:12], 12'h000};
        ok = 1'b1; sel = 0; a = 0; b = 0;
        if (opc == 7'h33) begin
            a = rs1; b = rs2;
            sel = BASE_SEL[f3];
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) sel = sel + 1;
            else if (f7 != 7'h00) ok = 1'b0;
        end else if (opc == 7'h13) begin
            a = rs1; b = imm_i;
            sel = BASE_SEL[f3];
            if (f3 == 3'd1) begin
                b = 32'(inst[24:20]);
                ok = (f7 == 7'h00);
            end else if (f3 == 3'd5) begin
                b = 32'(inst[24:20]);
                if (f7 == 7'h20) sel = sel + 1;
                else if (f7 != 7'h00) ok = 1'b0;
            end
        end else if (opc == 7'h37) begin
            sel = 10; b = imm_u;
        end else if (opc == 7'h17) begin
            sel = 0; a = pc; b = imm_u;
        end else begin
            ok = 1'b0;
        end
        r.rd = inst[11:7];
        if (ok) begin
            r.ill = 1'b0; r.wen = (inst[11:7] != 5'd0);
            r.opsel = 4'(sel); r.op1 = a; r.op2 = b;
        end else begin
            r.ill = 1'b1; r.wen = 1'b0; r.opsel = 4'd0; r.op1 = 0; r.op2 = 0;
        end
        return r;
    endfunction

    // One clock of stimulus. Samples the DUT before the edge and updates the queue model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] pc, input logic rdy,
                        output logic acc, output logic drn, output op_t got, output op_t exp,
                        output logic got_v, output logic got_r, output logic exp_v,
                        output logic exp_r);
        @(negedge i_clk);
        i_valid = v; i_inst = inst; i_rs1_data = rs1; i_rs2_data = rs2; i_pc = pc;
        i_ready = rdy;
        #1;
        got_v = o_valid;
        got_r = o_ready;
        got   = {o_illegal, o_wen, o_rd, o_opsel, o_op1, o_op2};
        exp_v = (q.size() != 0);
        exp_r = (q.size() < 2);
        drn   = exp_v && rdy;
        exp   = '0;
        if (drn) exp = q.pop_front();
        acc = v && exp_r;
        if (acc) q.push_back(model(inst, rs1, rs2, pc));
        @(posedge i_clk);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_inst = 0;
        i_rs1_data = 0; i_rs2_data = 0; i_pc = 0;
        q.delete();
        repeat (3) @(negedge i_clk);
        total++;
        if ({o_valid, o_ready, o_opsel, o_op1, o_op2, o_rd, o_wen, o_illegal} !==
            {1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0})
            $display("FAIL reset_values got v=%b r=%b sel=%h op1=%h op2=%h rd=%0d wen=%b ill=%b exp v=0 r=1 others 0",
                     o_valid, o_ready, o_opsel, o_op1, o_op2, o_rd, o_wen, o_illegal);
        else passed++;
        i_rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] insts [6] = '{32'h002081B3, 32'h40325213, 32'hFFF00093,
                                   32'h123452B7, 32'h00001317, 32'h00208033};
        logic [31:0] rs1s  [6] = '{32'd5, 32'h80000000, 32'd0, 32'd9, 32'd9, 32'd1};
        logic [31:0] rs2s  [6] = '{32'd7, 32'd1, 32'd2, 32'd3, 32'd4, 32'd2};
        op_t want [6];
        logic acc, drn, gv, gr, ev, er;
        op_t got, exp;
        want[0] = {1'b0, 1'b1, 5'd3, 4'h0, 32'd5, 32'd7};
        want[1] = {1'b0, 1'b1, 5'd4, 4'h7, 32'h80000000, 32'd3};
        want[2] = {1'b0, 1'b1, 5'd1, 4'h0, 32'd0, 32'hFFFFFFFF};
        want[3] = {1'b0, 1'b1, 5'd5, 4'hA, 32'd0, 32'h12345000};
        want[4] = {1'b0, 1'b1, 5'd6, 4'h0, 32'h100, 32'h1000};
        want[5] = {1'b0, 1'b0, 5'd0, 4'h0, 32'd1, 32'd2};
        for (int k = 0; k < 6; k++) begin
            step(1'b1, insts[k], rs1s[k], rs2s[k], 32'h100, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
            total++;
            if (gv !== 1'b1 || got !== want[k])
                $display("FAIL directed_%0d got v=%b op=%h exp v=1 op=%h", k, gv, got, want[k]);
            else passed++;
        end
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
        total++;
        if (gv !== 1'b0) $display("FAIL directed_idle got v=%b exp v=0", gv);
        else passed++;
    endtask

    task automatic test_stall;
        logic [31:0] insts [3] = '{32'h00110133, 32'h402181B3, 32'h00427233};
        logic acc, drn, gv, gr, ev, er;
        op_t got, exp;
        int idx, drained;
        step(1'b1, insts[0], 32'd10, 32'd1, 32'd0, 1'b0, acc, drn, got, exp, gv, gr, ev, er);
        step(1'b1, insts[1], 32'd20, 32'd2, 32'd0, 1'b0, acc, drn, got, exp, gv, gr, ev, er);
        total++;
        if (gr !== 1'b1) $display("FAIL stall_ready_before_full got=%b exp=1", gr);
        else passed++;
        step(1'b1, insts[2], 32'd30, 32'd3, 32'd0, 1'b0, acc, drn, got, exp, gv, gr, ev, er);
        total++;
        if (gr !== 1'b0 || acc !== 1'b0) $display("FAIL stall_ready_full got=%b exp=0", gr);
        else passed++;
        step(1'b1, insts[2], 32'd30, 32'd3, 32'd0, 1'b0, acc, drn, got, exp, gv, gr, ev, er);
        total++;
        if (gv !== 1'b1 || got !== model(insts[0], 32'd10, 32'd1, 32'd0))
            $display("FAIL stall_hold got=%h exp=%h", got, model(insts[0], 32'd10, 32'd1, 32'd0));
        else passed++;
        idx = 2; drained = 0;
        for (int k = 0; k < 3; k++) begin
            step((idx == 2) ? 1'b1 : 1'b0, insts[2], 32'd30, 32'd3, 32'd0, 1'b1,
                 acc, drn, got, exp, gv, gr, ev, er);
            if (acc) idx = 3;
            total++;
            if (gv !== 1'b1 || got !== exp)
                $display("FAIL stall_order_%0d got v=%b op=%h exp v=1 op=%h", k, gv, got, exp);
            else passed++;
        end
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
        total++;
        if (gv !== 1'b0 || gr !== 1'b1) $display("FAIL stall_drained got v=%b r=%b exp v=0 r=1", gv, gr);
        else passed++;
    endtask

    task automatic test_illegal;
        logic [31:0] insts [2] = '{32'h0000007F, 32'h022081B3};
        op_t want [2];
        logic acc, drn, gv, gr, ev, er;
        op_t got, exp;
`ifdef ALU_ISSUE_STATS_EN
        logic [31:0] ill0, iss0;
        ill0 = o_illegal_cnt; iss0 = o_issue_cnt;
`endif
        want[0] = {1'b1, 1'b0, 5'd0, 4'h0, 32'd0, 32'd0};
        want[1] = {1'b1, 1'b0, 5'd3, 4'h0, 32'd0, 32'd0};
        for (int k = 0; k < 2; k++) begin
            step(1'b1, insts[k], 32'hAAAA5555, 32'h1234, 32'h40, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
            total++;
            if (gv !== 1'b1 || got !== want[k])
                $display("FAIL illegal_%0d got v=%b op=%h exp v=1 op=%h", k, gv, got, want[k]);
            else passed++;
        end
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
`ifdef ALU_ISSUE_STATS_EN
        total++;
        if (o_illegal_cnt - ill0 !== 32'd2 || o_issue_cnt - iss0 !== 32'd2)
            $display("FAIL stats_counts got ill_delta=%0d iss_delta=%0d exp 2 2",
                     o_illegal_cnt - ill0, o_issue_cnt - iss0);
        else passed++;
`endif
    endtask

    task automatic test_reset_full;
        logic acc, drn, gv, gr, ev, er;
        op_t got, exp;
        step(1'b1, 32'h002081B3, 32'd1, 32'd1, 32'd0, 1'b0, acc, drn, got, exp, gv, gr, ev, er);
        step(1'b1, 32'h002081B3, 32'd2, 32'd2, 32'd0, 1'b0, acc, drn, got, exp, gv, gr, ev, er);
        @(negedge i_clk);
        total++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1) $display("FAIL rst_full_pre got v=%b r=%b exp v=1 r=0", o_valid, o_ready);
        else passed++;
        #2 i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, o_ready, o_opsel, o_op1, o_op2, o_rd, o_wen, o_illegal} !==
            {1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0})
            $display("FAIL rst_full_async got v=%b r=%b op1=%h rd=%0d exp v=0 r=1 op1=0 rd=0",
                     o_valid, o_ready, o_op1, o_rd);
        else passed++;
        q.delete();
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
        total++;
        if (gv !== 1'b1 || got !== {1'b0, 1'b1, 5'd3, 4'h0, 32'd5, 32'd7})
            $display("FAIL rst_full_post got v=%b op=%h exp v=1 op=%h", gv, got,
                     {1'b0, 1'b1, 5'd3, 4'h0, 32'd5, 32'd7});
        else passed++;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0] f7s [3];
        int k;
        w = $urandom;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'($urandom);
        k = $urandom_range(0, 5);
        case (k)
            0: begin w[6:0] = 7'h33; w[31:25] = f7s[$urandom_range(0, 2)]; end
            1: w[6:0] = 7'h13;
            2: begin
                w[6:0] = 7'h13; w[31:25] = f7s[$urandom_range(0, 2)];
                w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1;
            end
            3: w[6:0] = 7'h37;
            4: w[6:0] = 7'h17;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_random;
        logic acc, drn, gv, gr, ev, er;
        op_t got, exp;
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), rand_inst(), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 2) != 0), acc, drn, got, exp, gv, gr, ev, er);
            total++;
            if (gv !== ev || gr !== er)
                $display("FAIL rand_handshake_%0d got v=%b r=%b exp v=%b r=%b", n, gv, gr, ev, er);
            else passed++;
            if (drn) begin
                total++;
                if (got !== exp) $display("FAIL rand_data_%0d got=%h exp=%h", n, got, exp);
                else passed++;
            end
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, drn, got, exp, gv, gr, ev, er);
            total++;
            if (gv !== ev || (drn && got !== exp))
                $display("FAIL rand_tail_%0d got v=%b op=%h exp v=%b op=%h", n, gv, got, ev, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_illegal();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
